param_cache_system: RTL and testbench

PARAM_CACHE_SYSTEM -- requirements
Module: param_cache_system

---
 rtl/param_cache_system.sv | 201 ++++++++++++++++++++
 tb/tb_param_cache_system.sv | 387 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/param_cache_system.sv
// param_cache_system: direct-mapped, write-back, write-allocate cache with a
// word-serial memory port. Each line holds 2^OFFSET_W words; victims that are
// valid and dirty are written back word by word before the refill.
// Optional build macro PCACHE_STATS_EN adds saturating hit/miss counters; when
// it is undefined hit_cnt/miss_cnt are constant zero and no counter flops exist.
module param_cache_system #(
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 16,
    parameter int INDEX_W  = 6,
    parameter int OFFSET_W = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_rd,
    input  logic              req_wr,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              req_rdy,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_hit,
    output logic              err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [15:0]       hit_cnt,
    output logic [15:0]       miss_cnt
);

    localparam int TAG_W = ADDR_W - INDEX_W - OFFSET_W;
    localparam int LINES = 1 << INDEX_W;
    localparam int WORDS = 1 << (INDEX_W + OFFSET_W);

    typedef enum logic [1:0] {IDLE, COMPARE, WB, FILL} state_t;

    state_t              state;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic                rd_q;
    logic                wr_q;
    logic                refill;
    logic [OFFSET_W-1:0] cnt;
    logic [LINES-1:0]    valid;
    logic [LINES-1:0]    dirty;

    logic [TAG_W-1:0]    tag_mem  [LINES];
    logic [DATA_W-1:0]   data_mem [WORDS];

    logic [TAG_W-1:0]    tag_f;
    logic [INDEX_W-1:0]  idx;
    logic [OFFSET_W-1:0] off;
    logic [OFFSET_W-1:0] cnt_nxt;
    logic                bad;
    logic                in_cmp;
    logic                tag_hit;
    logic                hit_ok;
    logic                wr_hit;
    logic                fill_ack;
    logic                last;

    assign tag_f    = addr_q[ADDR_W-1:INDEX_W+OFFSET_W];
    assign idx      = addr_q[INDEX_W+OFFSET_W-1:OFFSET_W];
    assign off      = addr_q[OFFSET_W-1:0];
    assign cnt_nxt  = cnt + OFFSET_W'(1);
    assign last     = &cnt;
    assign bad      = rd_q & wr_q;
    assign in_cmp   = (state == COMPARE);
    assign tag_hit  = valid[idx] && (tag_mem[idx] == tag_f);
    assign hit_ok   = in_cmp && !bad && tag_hit;
    assign wr_hit   = hit_ok && wr_q;
    assign fill_ack = (state == FILL) && mem_ack;

    // The response is produced during the COMPARE cycle itself, giving a
    // one-cycle hit latency; a conflicting rd+wr request answers with err.
    assign req_rdy   = (state == IDLE);
    assign rsp_valid = in_cmp && (bad || tag_hit);
    assign err       = in_cmp && bad;
    assign rsp_hit   = hit_ok && !refill;
    assign rsp_rdata = (hit_ok && rd_q) ? data_mem[{idx, off}] : '0;

    // Control FSM: request capture, lookup, write-back and refill sequencing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            rd_q      <= 1'b0;
            wr_q      <= 1'b0;
            refill    <= 1'b0;
            cnt       <= '0;
            valid     <= '0;
            dirty     <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_rd || req_wr) begin
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        rd_q    <= req_rd;
                        wr_q    <= req_wr;
                        refill  <= 1'b0;
                        state   <= COMPARE;
                    end
                end
                COMPARE: begin
                    if (bad || tag_hit) begin
                        if (!bad && wr_q) begin
                            dirty[idx] <= 1'b1;
                        end
                        state <= IDLE;
                    end else begin
                        cnt     <= '0;
                        mem_req <= 1'b1;
                        if (valid[idx] && dirty[idx]) begin
                            state     <= WB;
                            mem_we    <= 1'b1;
                            mem_addr  <= {tag_mem[idx], idx, {OFFSET_W{1'b0}}};
                            mem_wdata <= data_mem[{idx, {OFFSET_W{1'b0}}}];
                        end else begin
                            state    <= FILL;
                            mem_we   <= 1'b0;
                            mem_addr <= {tag_f, idx, {OFFSET_W{1'b0}}};
                        end
                    end
                end
                WB: begin
                    if (mem_ack) begin
                        cnt <= cnt_nxt;
                        if (last) begin
                            // Write-back done; the port stays requested and
                            // turns straight into the first refill read.
                            state    <= FILL;
                            mem_we   <= 1'b0;
                            mem_addr <= {tag_f, idx, {OFFSET_W{1'b0}}};
                        end else begin
                            mem_addr  <= {tag_mem[idx], idx, cnt_nxt};
                            mem_wdata <= data_mem[{idx, cnt_nxt}];
                        end
                    end
                end
                FILL: begin
                    if (mem_ack) begin
                        cnt <= cnt_nxt;
                        if (last) begin
                            mem_req    <= 1'b0;
                            valid[idx] <= 1'b1;
                            dirty[idx] <= 1'b0;
                            refill     <= 1'b1;
                            state      <= COMPARE;
                        end else begin
                            mem_addr <= {tag_f, idx, cnt_nxt};
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Tag and data storage: written by refill words and by write hits only,
    // deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (fill_ack) begin
            data_mem[{idx, cnt}] <= mem_rdata;
        end else if (wr_hit) begin
            data_mem[{idx, off}] <= wdata_q;
        end
        if (fill_ack && last) begin
            tag_mem[idx] <= tag_f;
        end
    end

`ifdef PCACHE_STATS_EN
    // Saturating counters: first-lookup hits and misses; error requests and
    // the post-refill lookup are not counted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else begin
            if (hit_ok && !refill && hit_cnt != 16'hFFFF) begin
                hit_cnt <= hit_cnt + 16'd1;
            end
            if (in_cmp && !bad && !tag_hit && miss_cnt != 16'hFFFF) begin
                miss_cnt <= miss_cnt + 16'd1;
            end
        end
    end
`else
    assign hit_cnt  = '0;
    assign miss_cnt = '0;
`endif

endmodule

// File: tb/tb_param_cache_system.sv
// Self-checking bench for param_cache_system (default parameters). A word-level
// architectural model (latest value per address plus resident-line bookkeeping)
// predicts responses and the exact memory transfer sequence; a responder with
// programmable ack delay plays the memory.
module tb_param_cache_system;

`ifdef PCACHE_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    typedef struct packed {
        logic        we;
        logic [15:0] addr;
        logic [15:0] data;
    } xfer_t;

    logic        clk;
    logic        rst_n;
    logic        req_rd;
    logic        req_wr;
    logic [15:0] req_addr;
    logic [15:0] req_wdata;
    logic        req_rdy;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic        rsp_hit;
    logic        err;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_ack;
    logic [15:0] mem_rdata;
    logic [15:0] hit_cnt;
    logic [15:0] miss_cnt;

    param_cache_system #(
        .ADDR_W  (16),
        .DATA_W  (16),
        .INDEX_W (6),
        .OFFSET_W(2)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_rd   (req_rd),
        .req_wr   (req_wr),
        .req_addr (req_addr),
        .req_wdata(req_wdata),
        .req_rdy  (req_rdy),
        .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata),
        .rsp_hit  (rsp_hit),
        .err      (err),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_ack  (mem_ack),
        .mem_rdata(mem_rdata),
        .hit_cnt  (hit_cnt),
        .miss_cnt (miss_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Memory contents and architectural (program-visible) value of every word.
    logic [15:0] mem_arr [0:65535];
    logic [15:0] shadow  [0:65535];
    // Which block each line holds and whether it differs from memory.
    bit          m_valid [64];
    bit          m_dirty [64];
    logic [7:0]  m_tag   [64];
    int          m_hits;
    int          m_misses;

    xfer_t       exp_q[$];
    bit          exp_pend;
    bit          exp_rd;
    bit          exp_hit;
    bit          exp_err;
    logic [15:0] exp_rdata;

    int          mem_delay;
    int          wcnt;
    int          rd_acks;
    bit          prev_pend;
    logic        prev_we;
    logic [15:0] prev_addr;
    logic [15:0] prev_wdata;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 64; i++) begin
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
        end
        for (int a = 0; a < 65536; a++) shadow[a] = mem_arr[a];
        m_hits   = 0;
        m_misses = 0;
        exp_q.delete();
        exp_pend = 1'b0;
    endtask

    // Predict one request: response fields, and on a miss the write-back of the
    // resident block (if modified) followed by the refill of the new block.
    task automatic model_apply(input logic rd, input logic wr, input logic [15:0] a, input logic [15:0] d);
        int         idx;
        logic [7:0] tag;
        bit         hit;
        xfer_t      x;
        idx = int'(a[7:2]);
        tag = a[15:8];
        if (rd && wr) begin
            exp_err = 1'b1;
            exp_hit = 1'b0;
            exp_rd  = 1'b0;
        end else begin
            hit = m_valid[idx] && (m_tag[idx] == tag);
            if (!hit) begin
                if (m_valid[idx] && m_dirty[idx]) begin
                    for (int k = 0; k < 4; k++) begin
                        x.we   = 1'b1;
                        x.addr = {m_tag[idx], a[7:2], 2'(k)};
                        x.data = shadow[x.addr];
                        exp_q.push_back(x);
                    end
                end
                for (int k = 0; k < 4; k++) begin
                    x.we   = 1'b0;
                    x.addr = {tag, a[7:2], 2'(k)};
                    x.data = 16'h0;
                    exp_q.push_back(x);
                end
                m_valid[idx] = 1'b1;
                m_tag[idx]   = tag;
                m_dirty[idx] = 1'b0;
                m_misses++;
            end else begin
                m_hits++;
            end
            if (wr) begin
                shadow[a]    = d;
                m_dirty[idx] = 1'b1;
            end
            exp_err   = 1'b0;
            exp_hit   = hit;
            exp_rd    = rd;
            exp_rdata = shadow[a];
        end
        exp_pend = 1'b1;
    endtask

    // Monitor and memory responder, evaluated on the falling edge.
    always @(negedge clk) begin
        xfer_t e;
        if (!rst_n) begin
            mem_ack   = 1'b0;
            wcnt      = 0;
            prev_pend = 1'b0;
        end else begin
            if (prev_pend)
                chk("mem_hold", {mem_req, mem_we, mem_addr, mem_wdata},
                    {1'b1, prev_we, prev_addr, prev_wdata});
            if (!rsp_valid) begin
                chk("err_idle", err, 1'b0);
            end else begin
                chk("rsp_expected", exp_pend, 1'b1);
                chk("rsp_err", err, exp_err);
                chk("rsp_hit", rsp_hit, exp_hit);
                if (exp_rd) chk("rsp_rdata", rsp_rdata, exp_rdata);
                exp_pend = 1'b0;
            end
            mem_ack = 1'b0;
            if (mem_req) begin
                if (wcnt >= mem_delay) begin
                    wcnt = 0;
                    chk("mem_xfer_expected", exp_q.size() > 0, 1'b1);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        chk("mem_xfer", {mem_we, mem_addr, mem_we ? mem_wdata : 16'h0},
                            {e.we, e.addr, e.we ? e.data : 16'h0});
                    end
                    if (mem_we) begin
                        mem_arr[mem_addr] = mem_wdata;
                    end else begin
                        mem_rdata = mem_arr[mem_addr];
                        rd_acks++;
                    end
                    mem_ack = 1'b1;
                end else begin
                    wcnt++;
                end
            end else if ($urandom_range(0, 7) == 0) begin
                // Stray ack with no request outstanding must be ignored.
                mem_ack   = 1'b1;
                mem_rdata = 16'($urandom);
            end
            prev_pend  = mem_req && !mem_ack;
            prev_we    = mem_we;
            prev_addr  = mem_addr;
            prev_wdata = mem_wdata;
        end
    end

    task automatic do_req(input logic rd, input logic wr, input logic [15:0] a, input logic [15:0] d,
                          output int lat, output logic [15:0] g_rdata, output logic g_hit, output logic g_err);
        int k;
        k = 0;
        while (!req_rdy && k < 500) begin
            @(negedge clk);
            k++;
        end
        chk("req_rdy_wait", req_rdy, 1'b1);
        model_apply(rd, wr, a, d);
        req_rd    = rd;
        req_wr    = wr;
        req_addr  = a;
        req_wdata = d;
        @(posedge clk);
        @(negedge clk);
        lat = 1;
        while (!rsp_valid && lat < 3000) begin
            req_rd    = 1'($urandom_range(0, 1));
            req_wr    = 1'($urandom_range(0, 1));
            req_addr  = 16'($urandom);
            req_wdata = 16'($urandom);
            @(negedge clk);
            lat++;
        end
        req_rd  = 1'b0;
        req_wr  = 1'b0;
        g_rdata = rsp_rdata;
        g_hit   = rsp_hit;
        g_err   = err;
        chk("rsp_arrived", rsp_valid, 1'b1);
        chk("xfers_left", exp_q.size(), 0);
        @(posedge clk);
        #1;
        chk("hit_cnt", hit_cnt, STATS ? 16'(m_hits) : 16'h0);
        chk("miss_cnt", miss_cnt, STATS ? 16'(m_misses) : 16'h0);
    endtask

    initial begin
        int          lat;
        int          k;
        int          base;
        int          r;
        logic [15:0] gr;
        logic        gh;
        logic        ge;
        logic        rd;
        logic        wr;
        logic [15:0] a;

        req_rd    = 1'b0;
        req_wr    = 1'b0;
        req_addr  = 16'h0;
        req_wdata = 16'h0;
        mem_ack   = 1'b0;
        mem_rdata = 16'h0;
        mem_delay = 0;
        wcnt      = 0;
        rd_acks   = 0;
        prev_pend = 1'b0;
        for (int i = 0; i < 65536; i++) mem_arr[i] = 16'(i) ^ 16'h5A00;
        model_reset();

        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_req_rdy", req_rdy, 1'b1);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_rsp_hit", rsp_hit, 1'b0);
        chk("rst_rsp_rdata", rsp_rdata, 16'h0);
        chk("rst_mem", {mem_req, mem_we, mem_addr, mem_wdata}, 34'h0);
        chk("rst_counts", {hit_cnt, miss_cnt}, 32'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Cold read, then the same word again.
        do_req(1'b1, 1'b0, 16'h0010, 16'h0, lat, gr, gh, ge);
        chk("cold_rdata", gr, 16'h5A10);
        chk("cold_hit", gh, 1'b0);
        do_req(1'b1, 1'b0, 16'h0010, 16'h0, lat, gr, gh, ge);
        chk("warm_latency", lat, 1);
        chk("warm_hit", gh, 1'b1);
        chk("warm_rdata", gr, 16'h5A10);
        chk("stats_hit_literal", hit_cnt, STATS ? 16'd1 : 16'd0);
        chk("stats_miss_literal", miss_cnt, STATS ? 16'd1 : 16'd0);

        // Write hit, then a conflicting read forcing write-back and refill.
        do_req(1'b0, 1'b1, 16'h0011, 16'hBEEF, lat, gr, gh, ge);
        chk("wr_hit_latency", lat, 1);
        chk("wr_hit", gh, 1'b1);
        do_req(1'b1, 1'b0, 16'h0111, 16'h0, lat, gr, gh, ge);
        chk("evict_hit", gh, 1'b0);
        chk("evict_rdata", gr, 16'h5B11);
        chk("wb_mem_0011", mem_arr[16'h0011], 16'hBEEF);
        chk("wb_mem_0012", mem_arr[16'h0012], 16'h5A12);

        // Slow memory: 5 waiting cycles before each ack.
        mem_delay = 5;
        do_req(1'b1, 1'b0, 16'h0210, 16'h0, lat, gr, gh, ge);
        chk("slow_rdata", gr, 16'h5810);
        chk("slow_hit", gh, 1'b0);
        chk("slow_latency_floor", lat >= 24, 1'b1);
        mem_delay = 0;

        // Conflicting read+write request.
        do_req(1'b1, 1'b1, 16'h0020, 16'h1234, lat, gr, gh, ge);
        chk("rdwr_latency", lat, 1);
        chk("rdwr_err", ge, 1'b1);
        chk("rdwr_hit", gh, 1'b0);
        chk("rdwr_no_mem", mem_req, 1'b0);
        do_req(1'b1, 1'b0, 16'h0020, 16'h0, lat, gr, gh, ge);
        chk("after_err_miss", gh, 1'b0);
        chk("after_err_rdata", gr, 16'h5A20);

        // Random traffic over a few conflicting blocks in four lines.
        for (int i = 0; i < 300; i++) begin
            r  = int'($urandom_range(0, 15));
            rd = (r < 7) || (r == 15);
            wr = (r >= 7);
            a  = 16'(($urandom_range(0, 3) << 8) | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3));
            mem_delay = ($urandom_range(0, 9) == 0) ? 5 : int'($urandom_range(0, 3));
            do_req(rd, wr, a, 16'($urandom), lat, gr, gh, ge);
            if (!rd && wr) chk("rand_wr_rdata_zero", gr, 16'h0);
        end

        // Reset during the second refill word.
        mem_delay = 5;
        model_apply(1'b1, 1'b0, 16'h0730, 16'h0);
        base      = rd_acks;
        req_rd    = 1'b1;
        req_addr  = 16'h0730;
        @(posedge clk);
        #1 req_rd = 1'b0;
        k = 0;
        while (rd_acks < base + 1 && k < 200) begin
            @(posedge clk);
            k++;
        end
        chk("fill_word1_done", rd_acks - base, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_mem_req", mem_req, 1'b0);
        chk("abort_req_rdy", req_rdy, 1'b1);
        chk("abort_rsp_valid", rsp_valid, 1'b0);
        chk("abort_mem_addr", mem_addr, 16'h0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n     = 1'b1;
        mem_delay = 0;
        @(posedge clk);
        #1;
        do_req(1'b1, 1'b0, 16'h0730, 16'h0, lat, gr, gh, ge);
        chk("post_abort_hit", gh, 1'b0);
        chk("post_abort_rdata", gr, 16'h5D30);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
        $fatal(1);
    end

endmodule
